// File: rtl/seq_window_responder_if.sv
// Handshake bundle for seq_window_responder: trigger/qualifier inputs,
// pass/fail pulses and the saturating statistics counters.
interface seq_window_responder_if #(
  parameter int CNT_W = 8
);
  logic             b0;
  logic             b1;
  logic             b2;
  logic             clr_cnt;
  logic             b3;
  logic             fail;
  logic             busy;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] drop_cnt;

  // Stimulus side: drives trigger, qualifiers and counter clear.
  modport master (
    output b0, b1, b2, clr_cnt,
    input  b3, fail, busy, pass_cnt, fail_cnt, drop_cnt
  );

  // Responder side.
  modport slave (
    input  b0, b1, b2, clr_cnt,
    output b3, fail, busy, pass_cnt, fail_cnt, drop_cnt
  );
endinterface

// File: rtl/seq_window_responder.sv
// Trigger/qualifier window responder. A trigger b0 opens a window of WIN
// clk edges; inside it the responder collects qualifier b2 (native) and
// qualifier b1 (resynchronised). Both seen -> one-cycle b3 pulse; window
// expiry -> one-cycle fail pulse. Saturating pass/fail/drop statistics.
module seq_window_responder #(
  parameter int WIN         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_window_responder_if.slave bus
);

  // Window counter holds the number of edges left, WIN..1 (WIN <= 15).
  localparam int                WCNT_W = 4;
  localparam logic [WCNT_W-1:0] WIN_LD = WCNT_W'(WIN);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              state_q;
  logic [WCNT_W-1:0]   win_q;
  logic                seen1_q;
  logic                seen2_q;
  logic                b3_q;
  logic                fail_q;
  logic [CNT_W-1:0]    pass_cnt_q;
  logic [CNT_W-1:0]    fail_cnt_q;
  logic [CNT_W-1:0]    drop_cnt_q;
  logic [SYNC_STAGES-1:0] b1_sync_p;

  logic b1_s;
  logic m1;
  logic m2;
  logic match;
  logic last;
  logic in_wait;
  logic pass_inc;
  logic fail_inc;
  logic drop_inc;

  // Saturating increment with a clear that overrides any increment.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             inc,
    input logic             clr
  );
    logic [CNT_W-1:0] r;
    r = c;
    if (clr) begin
      r = '0;
    end else if (inc && (c != {CNT_W{1'b1}})) begin
      r = c + CNT_W'(1);
    end
    return r;
  endfunction

  // b1 resynchroniser: the last flop is the value seen SYNC_STAGES edges ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1_sync_p <= '0;
    end else begin
      b1_sync_p <= {b1_sync_p[SYNC_STAGES-2:0], bus.b1};
    end
  end

  assign b1_s = b1_sync_p[SYNC_STAGES-1];

  // Window-edge qualifier merge and counter increment decode.
  always_comb begin
    in_wait  = (state_q == S_WAIT);
    m1       = seen1_q | b1_s;
    m2       = seen2_q | bus.b2;
    match    = m1 & m2;
    last     = (win_q == WCNT_W'(1));
    pass_inc = 1'b0;
    fail_inc = 1'b0;
    drop_inc = 1'b0;
    if (in_wait) begin
      pass_inc = match;
      fail_inc = ~match & last;
      drop_inc = bus.b0;
    end
  end

  // IDLE/WAIT state machine with registered pass/fail pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      seen1_q <= 1'b0;
      seen2_q <= 1'b0;
      b3_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      b3_q   <= 1'b0;
      fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.b0) begin
            state_q <= S_WAIT;
            win_q   <= WIN_LD;
            seen1_q <= 1'b0;
            seen2_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (match) begin
            b3_q    <= 1'b1;
            state_q <= S_IDLE;
          end else if (last) begin
            fail_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            seen1_q <= m1;
            seen2_q <= m2;
            win_q   <= win_q - WCNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating statistics; a clear on the same edge as an increment wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= sat_inc(pass_cnt_q, pass_inc, bus.clr_cnt);
      fail_cnt_q <= sat_inc(fail_cnt_q, fail_inc, bus.clr_cnt);
      drop_cnt_q <= sat_inc(drop_cnt_q, drop_inc, bus.clr_cnt);
    end
  end

  assign bus.b3       = b3_q;
  assign bus.fail     = fail_q;
  assign bus.busy     = (state_q == S_WAIT);
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_seq_window_responder.sv
// Testbench for seq_window_responder: directed scenarios push expected
// pass/fail pulses (kind and edge index) into a queue; a forked monitor
// pops and compares whenever b3 or fail appears.
module tb_seq_window_responder;

  localparam int CNT_W = 8;

  typedef struct {
    bit is_fail;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t q[$];

  seq_window_responder_if #(.CNT_W(CNT_W)) bus ();

  seq_window_responder #(
    .WIN(4),
    .SYNC_STAGES(2),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: after posedge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply inputs for the next posedge, return at the following negedge.
  task automatic tick(input logic a0, input logic a1, input logic a2,
                      input logic clr = 1'b0);
    bus.b0      = a0;
    bus.b1      = a1;
    bus.b2      = a2;
    bus.clr_cnt = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_pulse(input bit is_fail, input int at);
    exp_t e;
    e.is_fail = is_fail;
    e.cyc     = at;
    q.push_back(e);
  endtask

  initial begin
    int t;
    cyc         = 0;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.b0      = 1'b0;
    bus.b1      = 1'b0;
    bus.b2      = 1'b0;
    bus.clr_cnt = 1'b0;

    // Monitor: every b3/fail pulse must match the head of the queue.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && (bus.b3 || bus.fail)) begin
          chk("exclusive_b3_fail", int'(bus.b3 & bus.fail), 0);
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: b3=%0b fail=%0b at edge %0d, none required",
                     bus.b3, bus.fail, cyc);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_kind_is_fail", int'(bus.fail), int'(e.is_fail));
            chk("pulse_edge", cyc, e.cyc);
          end
        end
      end
    join_none

    // Reset state
    #1;
    chk("rst_b3", int'(bus.b3), 0);
    chk("rst_fail", int'(bus.fail), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pass_cnt", int'(bus.pass_cnt), 0);
    chk("rst_fail_cnt", int'(bus.fail_cnt), 0);
    chk("rst_drop_cnt", int'(bus.drop_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: pass, raw b1/b2 at T+1 only -> match at T+3
    t = cyc + 1;
    expect_pulse(1'b0, t + 3);
    tick(1'b1, 1'b0, 1'b0);
    chk("t1_busy_T", int'(bus.busy), 1);
    tick(1'b0, 1'b1, 1'b1);
    chk("t1_busy_T1", int'(bus.busy), 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("t1_busy_T2", int'(bus.busy), 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("t1_busy_T3_closed", int'(bus.busy), 0);
    chk("t1_pass_cnt", int'(bus.pass_cnt), 1);
    idle(4);

    // 2: fail, b2 never seen -> fail at T+4
    t = cyc + 1;
    expect_pulse(1'b1, t + 4);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    idle(3);
    chk("t2_fail_cnt", int'(bus.fail_cnt), 1);
    chk("t2_pass_cnt", int'(bus.pass_cnt), 1);
    idle(4);

    // 3: drop on the closing edge, back-to-back trigger on the next edge
    t = cyc + 1;
    expect_pulse(1'b0, t + 3);
    expect_pulse(1'b1, t + 8);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("t3_busy_T3", int'(bus.busy), 0);
    chk("t3_drop_T3", int'(bus.drop_cnt), 1);
    tick(1'b1, 1'b0, 1'b0);
    chk("t3_busy_T4", int'(bus.busy), 1);
    chk("t3_drop_T4", int'(bus.drop_cnt), 1);
    idle(4);
    chk("t3_pass_cnt", int'(bus.pass_cnt), 2);
    chk("t3_fail_cnt", int'(bus.fail_cnt), 2);
    idle(4);

    // 4: early b1 pulse at T-1, b2 at T+2 -> match at T+2
    tick(1'b0, 1'b1, 1'b0);
    t = cyc + 1;
    expect_pulse(1'b0, t + 2);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("t4_busy_closed", int'(bus.busy), 0);
    chk("t4_pass_cnt", int'(bus.pass_cnt), 3);
    idle(4);

    // 5: 300 failing triggers saturate fail_cnt, then clear on a fail edge
    for (int i = 0; i < 300; i++) begin
      t = cyc + 1;
      expect_pulse(1'b1, t + 4);
      tick(1'b1, 1'b0, 1'b0);
      idle(4);
    end
    chk("t5_fail_cnt_sat", int'(bus.fail_cnt), 255);
    chk("t5_drop_cnt", int'(bus.drop_cnt), 1);
    t = cyc + 1;
    expect_pulse(1'b1, t + 4);
    tick(1'b1, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_fail_cnt_clr", int'(bus.fail_cnt), 0);
    chk("t5_pass_cnt_clr", int'(bus.pass_cnt), 0);
    chk("t5_drop_cnt_clr", int'(bus.drop_cnt), 0);
    idle(4);

    // 6: reset in the middle of a window
    t = cyc + 1;
    expect_pulse(1'b0, t + 3);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    idle(2);
    chk("t6_pre_pass_cnt", int'(bus.pass_cnt), 1);
    idle(3);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("t6_busy_before_rst", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy_async", int'(bus.busy), 0);
    chk("t6_b3_async", int'(bus.b3), 0);
    chk("t6_pass_cnt_async", int'(bus.pass_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1);
    idle(3);
    chk("t6_busy_after", int'(bus.busy), 0);
    chk("t6_pass_cnt", int'(bus.pass_cnt), 0);
    chk("t6_fail_cnt", int'(bus.fail_cnt), 0);
    chk("t6_drop_cnt", int'(bus.drop_cnt), 0);

    // Trigger on the very first edge after reset release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc + 1;
    expect_pulse(1'b1, t + 4);
    tick(1'b1, 1'b0, 1'b0);
    chk("t6_first_edge_busy", int'(bus.busy), 1);
    idle(5);
    chk("t6_first_edge_fail_cnt", int'(bus.fail_cnt), 1);
    idle(3);

    chk("pending_pulses", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_window_responder.md
# seq_window_responder

Single-clock responder that generates the `b3` response expected by the team's multiclock trigger/qualifier assertion. The block arms on trigger `b0` and opens a bounded window. Inside that window it collects qualifier `b2` (native `clk` domain) and qualifier `b1` (originating in the `clk1` domain, resynchronised internally). It pulses `b3` once both qualifiers have been seen, or pulses `fail` if the window expires first. It sits directly upstream of the assertion checker and also keeps saturating pass/fail/drop statistics.

## Interface
Parameters:
- `WIN`, default 4: window length in `clk` edges after the trigger; legal range 1..15.
- `SYNC_STAGES`, default 2: flop depth of the `b1` synchroniser; legal range 2..4.
- `CNT_W`, default 8: width of each statistics counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock; all state updates on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `b0` in 1: trigger.
- `b1` in 1: qualifier, asynchronous to `clk`.
- `b2` in 1: qualifier, synchronous to `clk`.
- `clr_cnt` in 1: synchronous clear of all counters.
- `b3` out 1: registered one-cycle pass pulse.
- `fail` out 1: registered one-cycle window-expired pulse.
- `busy` out 1: high while the window is open (decoded from the state register).
- `pass_cnt` out CNT_W: count of passes, saturating.
- `fail_cnt` out CNT_W: count of failures, saturating.
- `drop_cnt` out CNT_W: count of triggers ignored while busy, saturating.

## Operation
- `b1_s` is `b1` after a `SYNC_STAGES`-deep flop chain. At edge n, `b1_s` equals `b1` as sampled at edge n−SYNC_STAGES.
- State machine has two states: IDLE and WAIT.
- **IDLE:**
  - `b0`=1 at edge T moves the FSM to WAIT.
  - The window counter loads `WIN`.
  - Sticky flags `seen1` and `seen2` clear.
- **WAIT:** at each edge T+k, k = 1..WIN:
  - `m1` = `seen1` | `b1_s`; `m2` = `seen2` | `b2`.
  - If `m1` & `m2`: set `b3` to 1, increment `pass_cnt`, go to IDLE.
  - Else if k = WIN: set `fail` to 1, increment `fail_cnt`, go to IDLE.
  - Else: `seen1` <= `m1`, `seen2` <= `m2`, decrement the window counter.
- The window samples `b1_s` regardless of when the raw `b1` edge occurred. A `b1` pulse shortly before the trigger can therefore complete a match.
- A `b0` seen at any edge while in WAIT, including the edge that closes the window, is ignored and increments `drop_cnt`.
- `b0` is accepted again at the first edge with state IDLE.
- `b3` and `fail` are high for exactly one cycle. They are never high together.
- Counters:
  - Saturate at all-ones; never wrap.
  - `clr_cnt`=1 forces all three counters to 0 at that edge.
  - When `clr_cnt` coincides with an increment, clear wins and the result is 0.

## Timing
- Reset values, all outputs: `b3`=0, `fail`=0, `busy`=0, all counters 0.
- On reset, the state goes to IDLE and the synchroniser flops and sticky flags go to 0.
- Reset acts immediately on assertion, not at the next edge.
- Reset asserted mid-WAIT:
  - The outputs drop asynchronously and the window is abandoned.
  - No `b3` or `fail` is produced for that trigger.
  - The counters are zeroed.
- After `rst_n` deasserts, a `b0` at the first posedge is accepted.
- `busy` is high from edge T until the edge that closes the window.
- Pass latency:
  - Minimum: `b3` high between edges T+1 and T+2, when both qualifiers are present at T+1 (including `b1_s`).
  - Maximum: window closes at T+WIN.
- With raw `b1` and `b2` both high only at T+1, the match completes at T+1+SYNC_STAGES. This requires WIN ≥ 1+SYNC_STAGES.
- `b3` is asserted one edge after the match-completing edge, satisfying `|=> b3` at the downstream checker.
- Throughput: at most one trigger per WIN+1 edges in the worst case. A new trigger is accepted on the edge after the window closes.

## Test plan
1. **Pass.** Defaults. `b0`=1 at T; `b1`=`b2`=1 at T+1 only. Require:
   - `busy` high T..T+3.
   - `b3`=1 between T+3 and T+4.
   - `pass_cnt`=1, `fail`=0.
2. **Fail.** `b0` at T; `b1` at T+1; `b2` held 0. Require:
   - `fail`=1 between T+4 and T+5.
   - `fail_cnt`=1, `b3` never high.
3. **Drop / back-to-back.** `b0` at T; `b1`/`b2` at T+1; `b0` again at T+3 (closing edge) and at T+4. Require:
   - `drop_cnt`=1.
   - The second window opens at T+4 and `busy` is high from T+4.
4. **Early `b1`.** `b1` pulse at T−1; `b0` at T; `b2` at T+2. Require `b3` between T+2 and T+3.
5. **Saturation and clear.** 300 failing triggers with `CNT_W`=8. Require:
   - `fail_cnt`=255.
   - `clr_cnt` asserted on the edge where a fail completes gives `fail_cnt`=0.
6. **Reset mid-operation.** `b0` at T; `rst_n`=0 between T+1 and T+2; release; `b1`/`b2` high afterwards without a new `b0`. Require:
   - `busy` and `b3` drop to 0 immediately on reset.
   - No `b3` pulse afterwards.
   - All counters 0.
